// File: rtl/control_inicializacion_pkg.sv
// rtl/control_inicializacion_pkg.sv - shared state encodings, widths and defaults for the init controller
package control_inicializacion_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam int ADDR_W        = 6;
    localparam int LAST_ADDR_DEF = 12;

    // A one-cycle step still needs a 1-bit counter to exist.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/control_inicializacion_if.sv
// rtl/control_inicializacion_if.sv - request/status and init-table signals of the init controller
interface control_inicializacion_if;
    import control_inicializacion_pkg::*;

    logic              start;
    logic              listo_inicio;
    logic [ADDR_W-1:0] addr;
    logic              en;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        input  start, listo_inicio,
        output addr, en, busy, done, error
    );

    modport slave (
        output start, listo_inicio,
        input  addr, en, busy, done, error
    );

endinterface

// File: rtl/control_inicializacion_temporizador_paso.sv
// rtl/control_inicializacion_temporizador_paso.sv - step counter with registered tick at the last count
module temporizador_paso
    import control_inicializacion_pkg::*;
#(
    parameter int STEP_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = cnt_width(STEP_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] cnt;

    // tick tracks cnt==LAST in the same cycle, so it is precomputed from the next count.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt  <= '0;
            tick <= (STEP_CYCLES == 1);
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= (STEP_CYCLES == 1);
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= ((cnt + 1'b1) == LAST);
        end
    end

endmodule

// File: rtl/control_inicializacion.sv
// rtl/control_inicializacion.sv - walks the init table from address 1 to LAST_ADDR and reports done/error
module control_inicializacion
    import control_inicializacion_pkg::*;
#(
    parameter int STEP_CYCLES = 10,
    parameter int LAST_ADDR   = LAST_ADDR_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    control_inicializacion_if.master  bus
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              en_q, en_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic              error_q, error_n;
    logic              seen_q, seen_n;
    logic              tick;
    logic              ok;

    // Holding the counter cleared outside RUN guarantees count 0 on the first RUN cycle.
    temporizador_paso #(.STEP_CYCLES(STEP_CYCLES)) u_paso (
        .clk  (clk),
        .rst  (rst),
        .clr  (state != RUN),
        .tick (tick)
    );

    assign ok = seen_q || bus.listo_inicio;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            state   <= state_n;
            addr_q  <= addr_n;
            en_q    <= en_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            error_q <= error_n;
            seen_q  <= seen_n;
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = addr_q;
        en_n    = en_q;
        busy_n  = busy_q;
        done_n  = done_q;
        error_n = error_q;
        seen_n  = seen_q;
        case (state)
            RUN: begin
                if (en_q && bus.listo_inicio) seen_n = 1'b1;
                if (tick) begin
                    if (addr_q == LAST) begin
                        state_n = ok ? DONE : ERR;
                        addr_n  = '0;
                        en_n    = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = ok;
                        error_n = !ok;
                    end else begin
                        addr_n = addr_q + 1'b1;
                    end
                end
            end
            default: begin
                if (bus.start) begin
                    state_n = RUN;
                    addr_n  = ADDR_W'(1);
                    en_n    = 1'b1;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    error_n = 1'b0;
                    seen_n  = 1'b0;
                end
            end
        endcase
    end

    assign bus.addr  = addr_q;
    assign bus.en    = en_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.error = error_q;

endmodule

// File: tb/tb_control_inicializacion.sv
// tb/tb_control_inicializacion.sv - directed self-checking bench for control_inicializacion
module tb_control_inicializacion;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    control_inicializacion_if ia ();
    control_inicializacion_if ib ();

    control_inicializacion #(.STEP_CYCLES(4), .LAST_ADDR(12)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia.master)
    );

    control_inicializacion #(.STEP_CYCLES(1), .LAST_ADDR(12)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_a(input string tag, input int d, input int e);
        check({tag, ".addr"},  ia.addr,  0);
        check({tag, ".en"},    ia.en,    0);
        check({tag, ".busy"},  ia.busy,  0);
        check({tag, ".done"},  ia.done,  d);
        check({tag, ".error"}, ia.error, e);
    endtask

    // Full run on the 4-cycle DUT; listo_inicio is high for run cycles lo..hi.
    task automatic run_a(input string tag, input int lo, input int hi, input bit hold);
        ia.start = 1'b1;
        step(1);
        if (!hold) ia.start = 1'b0;
        for (int k = 0; k < 48; k++) begin
            check({tag, ".addr"}, ia.addr, k / 4 + 1);
            check({tag, ".en"},   ia.en,   1);
            check({tag, ".busy"}, ia.busy, 1);
            ia.listo_inicio = (k >= lo && k <= hi);
            step(1);
        end
        ia.listo_inicio = 1'b0;
    endtask

    initial begin
        ia.start = 1'b0; ia.listo_inicio = 1'b0;
        ib.start = 1'b0; ib.listo_inicio = 1'b0;
        step(2);
        rst = 1'b0;
        check_idle_a("reset", 0, 0);
        step(3);
        check_idle_a("idle_wait", 0, 0);

        run_a("ok_run", 44, 47, 1'b0);
        check_idle_a("ok_end", 1, 0);

        run_a("err_run", 99, 99, 1'b0);
        check_idle_a("err_end", 0, 1);

        ia.start = 1'b1;
        step(1);
        ia.start = 1'b0;
        check("restart_clears_err", ia.error, 0);
        step(16);
        check("abort.addr_before", ia.addr, 5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_idle_a("abort", 0, 0);
        step(3);
        check_idle_a("abort_stay", 0, 0);
        ia.start = 1'b1;
        step(1);
        ia.start = 1'b0;
        check("abort_restart.addr", ia.addr, 1);
        check("abort_restart.busy", ia.busy, 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;

        run_a("held_run", 44, 47, 1'b1);
        check_idle_a("held_end", 1, 0);
        step(1);
        ia.start = 1'b0;
        check("held_again.addr", ia.addr, 1);
        check("held_again.busy", ia.busy, 1);
        check("held_again.done", ia.done, 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;

        run_a("pulse_run", 45, 45, 1'b0);
        check_idle_a("pulse_end", 1, 0);

        ib.start = 1'b1;
        step(1);
        ib.start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            check("fast.addr", ib.addr, k + 1);
            check("fast.en", ib.en, 1);
            ib.listo_inicio = (k == 11);
            step(1);
        end
        ib.listo_inicio = 1'b0;
        check("fast_end.done", ib.done, 1);
        check("fast_end.error", ib.error, 0);
        check("fast_end.addr", ib.addr, 0);
        check("fast_end.busy", ib.busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/control_inicializacion.md
CONTROL_INICIALIZACION -- requirements
Module: control_inicializacion

Interface
REQ-001 Parameter STEP_CYCLES, default 10, SHALL set the clock cycles each table address is held (legal range 1..255).
REQ-002 Parameter LAST_ADDR, default 12, SHALL set the final table address of the init sequence (legal range 1..63).
REQ-003 clk  in  1  SHALL be the single system clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-005 start  in  1  SHALL request one init sequence; it is level-sampled on each clk edge.
REQ-006 listo_inicio  in  1  SHALL be the completion flag returned by the init table for the current address.
REQ-007 addr  out  6  SHALL be the init-table address; it is registered.
REQ-008 en  out  1  SHALL be the init-table enable; it is registered.
REQ-009 busy  out  1  SHALL be high while a sequence runs.
REQ-010 done  out  1  SHALL be high, held, after a successful sequence.
REQ-011 error  out  1  SHALL be high, held, after a sequence ends without listo_inicio.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, RUN, DONE, ERR.
REQ-013 In IDLE, DONE and ERR the block SHALL drive addr=0 and en=0.
REQ-014 start=1 in IDLE, DONE or ERR SHALL, on that edge, enter RUN with addr=1, en=1, busy=1, done=0, error=0, step counter=0, and the seen flag cleared.
REQ-015 start SHALL be ignored while in RUN.
REQ-016 In RUN, the step counter SHALL count 0..STEP_CYCLES-1; each addr value SHALL stay on the output for exactly STEP_CYCLES clocks.
REQ-017 When the counter reaches STEP_CYCLES-1 and addr<LAST_ADDR, the block SHALL increment addr by 1 and zero the counter on the next edge.
REQ-018 The sticky seen flag SHALL set on any RUN cycle with en=1 and listo_inicio=1.
REQ-019 When the counter reaches STEP_CYCLES-1 and addr=LAST_ADDR, the next state SHALL be DONE if the seen flag or the current listo_inicio is 1, else ERR.
REQ-020 On entering DONE or ERR, busy SHALL drop to 0 on the same edge, with addr=0 and en=0.
REQ-021 A sequence SHALL therefore occupy exactly LAST_ADDR*STEP_CYCLES clocks with en=1.
REQ-022 With STEP_CYCLES=1, addr SHALL advance on every clock.
REQ-023 The counter width SHALL be clog2(STEP_CYCLES), minimum 1 bit; addr SHALL never exceed LAST_ADDR and SHALL never wrap.
REQ-024 If start=1 on the same edge that RUN ends, the block SHALL enter DONE or ERR; the restart is taken on the following edge if start is still 1.
REQ-025 done and error SHALL be mutually exclusive at all times.

Reset
REQ-026 rst=1 SHALL, on the clock edge, force IDLE with addr=0, en=0, busy=0, done=0, error=0, counter=0, and the seen flag cleared.
REQ-027 rst SHALL override start and SHALL abort a sequence in progress with no partial-state retention.
REQ-028 After rst is released, the block SHALL stay in IDLE until start=1.

Structure
REQ-029 A shared package/include SHALL hold the state encodings, the 6-bit address width, and the LAST_ADDR default (12).
REQ-030 The step counter SHALL be one sub-module, temporizador_paso, with ports clk, rst, clr, and a registered tick output asserted at count STEP_CYCLES-1; the FSM stays in control_inicializacion.

Verification
REQ-031 STEP_CYCLES=4, 1-cycle start pulse, listo_inicio=1 at addr 12 -> addr steps 1..12, each 4 clocks; en high 48 clocks; then done=1, busy=0, addr=0.
REQ-032 Same setup with listo_inicio held 0 -> after 48 clocks error=1, done=0, en=0.
REQ-033 rst=1 for 1 clock while addr=5 -> next cycle IDLE, all outputs 0; a later start restarts from addr=1.
REQ-034 start held high throughout the run -> addr sequence is not restarted mid-run; after DONE, a new run begins one clock later with done cleared.
REQ-035 STEP_CYCLES=1 -> addr changes every clock 1..12; done asserts 12 clocks after addr=1 first appears.
REQ-036 listo_inicio pulsed for 1 clock at addr 12, count 1, then low -> done=1 (sticky seen flag).
